risc_decode: RTL and testbench

- RiSC-16 decode / operand-fetch stage; sits directly upstream of the ALU and feeds its func_alu, in1 and in2 inputs through a registered ID/EX boundary.
- Accepts fetched instructions over a valid/ready handshake.
- Reads the 8x16 register file and builds ALU operands plus control for downstream stages.
- Accepts the writeback port and handles pipeline flush.

---
 rtl/risc_pkg.sv | 57 +++++
 rtl/risc_regfile.sv | 50 +++++
 rtl/risc_decode.sv | 198 +++++++++++++++++++
 tb/tb_risc_decode.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the RiSC-16 decode stage and its neighbours.
//   - opcode constants (OP_ADD..OP_JALR)
//   - ALU function codes, shared with the alu module
//   - instruction field positions
//   - idex_t: the registered ID/EX payload
//   - sext7: sign-extend the 7-bit immediate to the datapath width
package risc_pkg;

    localparam int XLEN = 16;
    localparam int RIDX = 3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_NAND  = 2'd1;
    localparam logic [1:0] ALU_PASS1 = 2'd2;
    localparam logic [1:0] ALU_EQ    = 2'd3;

    localparam int OP_HI    = 15;
    localparam int OP_LO    = 13;
    localparam int RA_HI    = 12;
    localparam int RA_LO    = 10;
    localparam int RB_HI    = 9;
    localparam int RB_LO    = 7;
    localparam int RC_HI    = 2;
    localparam int RC_LO    = 0;
    localparam int SIMM_HI  = 6;
    localparam int IMM10_HI = 9;

    typedef struct packed {
        logic [1:0]      func;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [RIDX-1:0] dest;
        logic            rf_we;
        logic            mem_rd;
        logic            mem_wr;
        logic [XLEN-1:0] store_data;
        logic            is_beq;
        logic            is_jalr;
        logic [XLEN-1:0] br_target;
        logic [XLEN-1:0] jump_target;
        logic [XLEN-1:0] pc;
    } idex_t;

    function automatic logic [XLEN-1:0] sext7(input logic [6:0] v);
        return {{(XLEN-7){v[6]}}, v};
    endfunction

endpackage

// File: rtl/risc_regfile.sv
// risc_regfile: NREGS x WIDTH architectural register file.
//   clk, rst        : clock, synchronous active-high clear of every entry
//   ra_x_i/rd_x_o   : async read port X
//   ra_y_i/rd_y_o   : async read port Y
//   we_i/wa_i/wd_i  : synchronous write port
// r0 always reads 0 and ignores writes. A read of the register being written
// in the same cycle returns the write data (write-through bypass), so the
// decode stage never needs a separate forwarding path from writeback.
module risc_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] ra_x_i,
    output logic [WIDTH-1:0]         rd_x_o,
    input  logic [$clog2(NREGS)-1:0] ra_y_i,
    output logic [WIDTH-1:0]         rd_y_o,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] wa_i,
    input  logic [WIDTH-1:0]         wd_i
);

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd_x_o = mem_q[ra_x_i];
        if (ra_x_i == '0)
            rd_x_o = '0;
        else if (we_i && (wa_i == ra_x_i))
            rd_x_o = wd_i;
    end

    always_comb begin
        rd_y_o = mem_q[ra_y_i];
        if (ra_y_i == '0)
            rd_y_o = '0;
        else if (we_i && (wa_i == ra_y_i))
            rd_y_o = wd_i;
    end

endmodule

// File: rtl/risc_decode.sv
// risc_decode: RiSC-16 decode / operand-fetch stage with a registered ID/EX
// boundary feeding the ALU.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc : fetch handshake and instruction
//   flush                         : kill held and incoming op (taken branch/jump)
//   wb_en/wb_addr/wb_data         : register writeback port
//   out_valid/out_ready           : ID/EX handshake toward EX
//   func_alu, in1, in2            : ALU function and operands
//   dest, rf_we, mem_rd, mem_wr, store_data : writeback / memory control
//   is_beq, is_jalr, br_target, jump_target, pc_out : control-flow info
module risc_decode
    import risc_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_instr,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic                     flush,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [WIDTH-1:0]         wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               func_alu,
    output logic [WIDTH-1:0]         in1,
    output logic [WIDTH-1:0]         in2,
    output logic [$clog2(NREGS)-1:0] dest,
    output logic                     rf_we,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [WIDTH-1:0]         store_data,
    output logic                     is_beq,
    output logic                     is_jalr,
    output logic [WIDTH-1:0]         br_target,
    output logic [WIDTH-1:0]         jump_target,
    output logic [WIDTH-1:0]         pc_out
);

    localparam int AW = $clog2(NREGS);

    // Instruction fields
    logic [2:0]       op;
    logic [AW-1:0]    ra, rb, rc;
    logic [WIDTH-1:0] simm;

    assign op   = in_instr[OP_HI:OP_LO];
    assign ra   = in_instr[RA_HI:RA_LO];
    assign rb   = in_instr[RB_HI:RB_LO];
    assign rc   = in_instr[RC_HI:RC_LO];
    assign simm = sext7(in_instr[SIMM_HI:0]);

    // Port Y carries rC only for the two register-register ALU ops; every
    // other user of a second register (SW data, BEQ compare) names it in rA.
    logic [AW-1:0]    ry_addr;
    logic [WIDTH-1:0] x_val, y_val;

    assign ry_addr = ((op == OP_ADD) || (op == OP_NAND)) ? rc : ra;

    risc_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .ra_x_i (rb),
        .rd_x_o (x_val),
        .ra_y_i (ry_addr),
        .rd_y_o (y_val),
        .we_i   (wb_en),
        .wa_i   (wb_addr),
        .wd_i   (wb_data)
    );

    // Combinational decode of the presented instruction
    idex_t dec;

    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        unique case (op)
            OP_ADD: begin
                dec.func  = ALU_ADD;
                dec.in1   = x_val;
                dec.in2   = y_val;
                dec.dest  = ra;
                dec.rf_we = 1'b1;
            end
            OP_ADDI: begin
                dec.func  = ALU_ADD;
                dec.in1   = x_val;
                dec.in2   = simm;
                dec.dest  = ra;
                dec.rf_we = 1'b1;
            end
            OP_NAND: begin
                dec.func  = ALU_NAND;
                dec.in1   = x_val;
                dec.in2   = y_val;
                dec.dest  = ra;
                dec.rf_we = 1'b1;
            end
            OP_LUI: begin
                dec.func  = ALU_PASS1;
                dec.in1   = {in_instr[IMM10_HI:0], 6'b0};
                dec.dest  = ra;
                dec.rf_we = 1'b1;
            end
            OP_SW: begin
                dec.func       = ALU_ADD;
                dec.in1        = x_val;
                dec.in2        = simm;
                dec.mem_wr     = 1'b1;
                dec.store_data = y_val;
            end
            OP_LW: begin
                dec.func   = ALU_ADD;
                dec.in1    = x_val;
                dec.in2    = simm;
                dec.mem_rd = 1'b1;
                dec.dest   = ra;
                dec.rf_we  = 1'b1;
            end
            OP_BEQ: begin
                dec.func      = ALU_EQ;
                dec.in1       = y_val;
                dec.in2       = x_val;
                dec.is_beq    = 1'b1;
                dec.br_target = in_pc + WIDTH'(1) + simm;
            end
            OP_JALR: begin
                // Link value goes through the ALU as PASS1; pc+1 wraps mod 2^16.
                dec.func        = ALU_PASS1;
                dec.in1         = in_pc + WIDTH'(1);
                dec.dest        = ra;
                dec.rf_we       = 1'b1;
                dec.is_jalr     = 1'b1;
                dec.jump_target = x_val;
            end
            default: ;
        endcase
        // A write to r0 is architecturally a no-op; drop it here so later
        // stages never have to special-case it.
        if (dec.dest == '0) dec.rf_we = 1'b0;
    end

    // ID/EX register
    idex_t idex_q, idex_d;
    logic  out_valid_q, out_valid_d;
    logic  accept;

    // No skid buffer: a stalled EX directly stalls fetch.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        idex_d      = idex_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            idex_d      = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            idex_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            idex_q      <= idex_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign func_alu    = idex_q.func;
    assign in1         = idex_q.in1;
    assign in2         = idex_q.in2;
    assign dest        = idex_q.dest;
    assign rf_we       = idex_q.rf_we;
    assign mem_rd      = idex_q.mem_rd;
    assign mem_wr      = idex_q.mem_wr;
    assign store_data  = idex_q.store_data;
    assign is_beq      = idex_q.is_beq;
    assign is_jalr     = idex_q.is_jalr;
    assign br_target   = idex_q.br_target;
    assign jump_target = idex_q.jump_target;
    assign pc_out      = idex_q.pc;

endmodule

// File: tb/tb_risc_decode.sv
// tb_risc_decode: self-checking bench for risc_decode. A reference register
// array plus a queue of accepted ops model the stage; directed table vectors
// and hand sequences cover the listed corner cases, then random traffic runs.
module tb_risc_decode;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [15:0] in_instr, in_pc, wb_data, in1, in2, store_data;
    logic [15:0] br_target, jump_target, pc_out;
    logic [2:0]  wb_addr, dest;
    logic [1:0]  func_alu;
    logic        rf_we, mem_rd, mem_wr, is_beq, is_jalr;

    always #5 clk = ~clk;

    risc_decode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .func_alu(func_alu), .in1(in1), .in2(in2),
        .dest(dest), .rf_we(rf_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .store_data(store_data), .is_beq(is_beq), .is_jalr(is_jalr),
        .br_target(br_target), .jump_target(jump_target), .pc_out(pc_out)
    );

    typedef struct {
        logic [1:0]  func;
        logic [15:0] in1, in2;
        logic [2:0]  dest;
        logic        we, mrd, mwr;
        logic [15:0] sd;
        logic        beq, jalr;
        logic [15:0] br, jt, pc;
    } exp_t;

    typedef struct {
        logic [15:0] instr, pc;
        logic        wbe;
        logic [2:0]  wba;
        logic [15:0] wbd;
        logic [1:0]  f;
        logic [15:0] i1, i2;
        logic [2:0]  d;
        logic        we;
        logic [15:0] aux;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rf [8];
    exp_t        q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register read as seen by decode: r0 is zero, a same-cycle write wins.
    function automatic logic [15:0] rd(input logic [2:0] r);
        if (r == 3'd0) return 16'h0;
        if (wb_en && wb_addr == r) return wb_data;
        return rf[r];
    endfunction

    function automatic exp_t model_dec(input logic [15:0] i, input logic [15:0] pc);
        exp_t e;
        int   s;
        logic [2:0] a, b, c;
        a = i[12:10]; b = i[9:7]; c = i[2:0];
        s = int'(i[6:0]);
        if (s >= 64) s -= 128;
        e = '{default: 0};
        e.pc = pc;
        case (i[15:13])
            3'd0: begin e.in1 = rd(b); e.in2 = rd(c); e.dest = a; e.we = 1; end
            3'd1: begin e.in1 = rd(b); e.in2 = 16'(s); e.dest = a; e.we = 1; end
            3'd2: begin e.func = 1; e.in1 = rd(b); e.in2 = rd(c); e.dest = a; e.we = 1; end
            3'd3: begin e.func = 2; e.in1 = 16'(int'(i[9:0]) * 64); e.dest = a; e.we = 1; end
            3'd4: begin e.in1 = rd(b); e.in2 = 16'(s); e.mwr = 1; e.sd = rd(a); end
            3'd5: begin e.in1 = rd(b); e.in2 = 16'(s); e.mrd = 1; e.dest = a; e.we = 1; end
            3'd6: begin
                e.func = 3; e.in1 = rd(a); e.in2 = rd(b); e.beq = 1;
                e.br = 16'((int'(pc) + 1 + s + 65536) % 65536);
            end
            default: begin
                e.func = 2; e.in1 = 16'((int'(pc) + 1) % 65536); e.dest = a; e.we = 1;
                e.jalr = 1; e.jt = rd(b);
            end
        endcase
        if (e.dest == 3'd0) e.we = 0;
        return e;
    endfunction

    task automatic cmp_out(input exp_t e);
        chk("func_alu", func_alu, e.func);
        chk("in1", in1, e.in1);
        chk("in2", in2, e.in2);
        chk("dest", dest, e.dest);
        chk("rf_we", rf_we, e.we);
        chk("mem_rd", mem_rd, e.mrd);
        chk("mem_wr", mem_wr, e.mwr);
        chk("store_data", store_data, e.sd);
        chk("is_beq", is_beq, e.beq);
        chk("is_jalr", is_jalr, e.jalr);
        chk("br_target", br_target, e.br);
        chk("jump_target", jump_target, e.jt);
        chk("pc_out", pc_out, e.pc);
    endtask

    // One clock with the currently driven inputs; checks in_ready before the
    // edge and the ID/EX contents after it against the queue model.
    task automatic cyc();
        exp_t e;
        bit   qv, acc;
        #1;
        qv = (q.size() != 0);
        if (!rst) chk("in_ready", in_ready, !qv || out_ready);
        acc = in_valid && (!qv || out_ready) && !flush && !rst;
        e   = model_dec(in_instr, in_pc);
        @(posedge clk);
        if (rst) begin
            q.delete();
            for (int k = 0; k < 8; k++) rf[k] = 16'h0;
        end else begin
            if (wb_en && wb_addr != 3'd0) rf[wb_addr] = wb_data;
            if (flush) q.delete();
            else begin
                if (qv && out_ready) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end
        #1;
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) cmp_out(q[0]);
    endtask

    vec_t tbl [9];
    exp_t zero;

    initial begin
        zero = '{default: 0};
        for (int k = 0; k < 8; k++) rf[k] = 16'h0;
        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
        cyc(); cyc();
        rst = 0;
        cmp_out(zero);

        // r1 = 0x1234, r2 = 0x0F0F
        wb_en = 1; wb_addr = 3'd1; wb_data = 16'h1234; cyc();
        wb_addr = 3'd2; wb_data = 16'h0F0F; cyc();
        wb_en = 0;

        //             instr     pc        wbe wba   wbd       f   in1       in2       d   we  aux
        tbl[0] = '{16'h0C82, 16'h0010, 0, 3'd0, 16'h0000, 0, 16'h1234, 16'h0F0F, 3, 1, 16'h0000}; // ADD r3,r1,r2
        tbl[1] = '{16'h30FF, 16'h0011, 0, 3'd0, 16'h0000, 0, 16'h1234, 16'hFFFF, 4, 1, 16'h0000}; // ADDI r4,r1,-1
        tbl[2] = '{16'h77FF, 16'h0012, 0, 3'd0, 16'h0000, 2, 16'hFFC0, 16'h0000, 5, 1, 16'h0000}; // LUI r5,0x3FF
        tbl[3] = '{16'h5881, 16'h0013, 1, 3'd1, 16'hAAAA, 1, 16'hAAAA, 16'hAAAA, 6, 1, 16'h0000}; // NAND bypass
        tbl[4] = '{16'h0082, 16'h0014, 0, 3'd0, 16'h0000, 0, 16'hAAAA, 16'h0F0F, 0, 0, 16'h0000}; // ADD r0
        tbl[5] = '{16'hC505, 16'h0020, 0, 3'd0, 16'h0000, 3, 16'hAAAA, 16'h0F0F, 0, 0, 16'h0026}; // BEQ +5
        tbl[6] = '{16'hFC80, 16'hFFFF, 0, 3'd0, 16'h0000, 2, 16'h0000, 16'h0000, 7, 1, 16'hAAAA}; // JALR wrap
        tbl[7] = '{16'h8883, 16'h0030, 0, 3'd0, 16'h0000, 0, 16'hAAAA, 16'h0003, 0, 0, 16'h0F0F}; // SW r2,r1,3
        tbl[8] = '{16'hAD7E, 16'h0031, 0, 3'd0, 16'h0000, 0, 16'h0F0F, 16'hFFFE, 3, 1, 16'h0000}; // LW r3,r2,-2

        in_valid = 1;
        for (int k = 0; k < 9; k++) begin
            in_instr = tbl[k].instr; in_pc = tbl[k].pc;
            wb_en = tbl[k].wbe; wb_addr = tbl[k].wba; wb_data = tbl[k].wbd;
            cyc();
            chk("tbl_valid", out_valid, 1);
            chk("tbl_func", func_alu, tbl[k].f);
            chk("tbl_in1", in1, tbl[k].i1);
            chk("tbl_in2", in2, tbl[k].i2);
            chk("tbl_dest", dest, tbl[k].d);
            chk("tbl_we", rf_we, tbl[k].we);
            if (tbl[k].instr[15:13] == 3'd6) chk("tbl_br", br_target, tbl[k].aux);
            if (tbl[k].instr[15:13] == 3'd7) chk("tbl_jt", jump_target, tbl[k].aux);
            if (tbl[k].instr[15:13] == 3'd4) chk("tbl_sd", store_data, tbl[k].aux);
        end
        wb_en = 0; in_valid = 0; cyc();

        // Back-pressure: three stalled cycles, then B follows A exactly once
        out_ready = 0; in_valid = 1; in_instr = 16'h0C82; in_pc = 16'h0100; cyc();
        in_instr = 16'h30FF; in_pc = 16'h0101;
        repeat (3) begin
            cyc();
            chk("stall_ready", in_ready, 0);
            chk("stall_pc", pc_out, 16'h0100);
        end
        out_ready = 1; cyc();
        chk("bp_next_pc", pc_out, 16'h0101);
        chk("bp_next_in2", in2, 16'hFFFF);
        in_valid = 0; cyc();
        chk("bp_drain", out_valid, 0);

        // Flush kills held and incoming op; a same-cycle writeback still lands
        out_ready = 0; in_valid = 1; in_instr = 16'h0C82; in_pc = 16'h0200; cyc();
        flush = 1; in_instr = 16'h77FF; in_pc = 16'h0201;
        wb_en = 1; wb_addr = 3'd4; wb_data = 16'h4444; cyc();
        chk("flush_valid", out_valid, 0);
        flush = 0; wb_en = 0; in_valid = 0; cyc();
        chk("flush_dropped", out_valid, 0);
        out_ready = 1; in_valid = 1; in_instr = 16'h3600; in_pc = 16'h0202; cyc(); // ADDI r5,r4,0
        chk("flush_wb", in1, 16'h4444);
        in_valid = 0; cyc();

        // Reset during a stall discards the held op and clears the regfile
        out_ready = 0; in_valid = 1; in_instr = 16'h0C82; in_pc = 16'h0300; cyc();
        cyc();
        rst = 1; cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", pc_out, 16'h0000);
        rst = 0; out_ready = 1; in_instr = 16'h0C82; in_pc = 16'h0301; cyc();
        chk("rst_r1", in1, 16'h0000);
        in_valid = 0; cyc();

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 3'($urandom);
            wb_data   = 16'($urandom);
            in_instr  = 16'($urandom);
            in_pc     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            cyc();
        end
        rst = 0; flush = 0; in_valid = 0; wb_en = 0; out_ready = 1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
